hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
- Iterative multiply/divide unit with the architectural HI/LO registers, in the EX stage alongside the ALU.
- Operands arrive from the EX-stage forwarded operand muxes.
- Serves MULT/MULTU/DIV/DIVU, MTHI/MTLO writes and MFHI/MFLO reads.
- Its busy output feeds the hazard/stall logic; HI/LO values are what MFHI/MFLO forwarding paths ultimately fall back to.

Parameters:
- WIDTH, 32, operand and HI/LO register width.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W == WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a mult/div op; sampled only when busy=0.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  WIDTH  rs operand (multiplicand/dividend).
- b  input  WIDTH  rt operand (multiplier/divisor).
- mthi_we  input  1  write wdata into HI.
- mtlo_we  input  1  write wdata into LO.
- wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  operation in flight; pipeline stalls any MFHI/MFLO/mult/div while high.
- done  output  1  one-cycle pulse when HI/LO take a result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset, asynchronous, immediate: state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, internal accumulators=0. Reset mid-operation discards the op; no HI/LO update follows.
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - On an edge with start=1 (and no mt write that cycle): latch op, |a|/|b| (signed ops) or a/b (unsigned), result signs; counter=WIDTH-1; go to CALC.
  - Operands are never re-read after the start edge.
- CALC:
  - One radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide.
  - Counter decrements; at counter==0 go to FIX.
- FIX:
  - Apply sign correction; write hi/lo; done=1 for the following cycle; return to IDLE.
- Timing:
  - busy is 1 in exactly WIDTH+1 = 33 cycles after the start edge.
  - hi/lo and done change on the 33rd edge after the start edge.
  - busy=0 in the same cycle that done=1.
  - A new start may be accepted on the edge where done is high.
- Multiply: 2*WIDTH-bit product; hi = upper half, lo = lower half. MULT negates the 64-bit magnitude when the operand signs differ.
- Divide:
  - lo = quotient, hi = remainder.
  - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (DIV) gives lo=0x80000000, hi=0 (modulo wrap).
- Divide by zero: result computed normally through CALC (same 33-cycle latency); final hi = a as latched, lo = 0xFFFFFFFF, for both DIV and DIVU.
- MTHI/MTLO:
  - When busy=0, the write takes effect on that edge.
  - When mthi_we and mtlo_we are both set, both registers are written with wdata.
  - If start is also high on that edge, the write wins and start is ignored.
- MTHI/MTLO while busy=1:
  - The in-flight op is cancelled: FSM to IDLE, busy=0 next cycle, no done.
  - The selected register takes wdata; the other keeps its pre-op value.
- start while busy=1: ignored, no queueing.
- hi/lo only change on: reset, FIX completion, or an mt write.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high 33 cycles; hi=0xFFFFFFFE, lo=0x00000001; done pulses exactly once.
- MULT a=0xFFFFFFFD(-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; change a/b on cycle 2 -> result unchanged.
- DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU same operands -> lo=0x7FFFFFFC, hi=0x00000001. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=100 b=0 -> after 33 cycles lo=0xFFFFFFFF, hi=0x00000064.
- Preload hi=0x11, lo=0x22; start MULTU 5*6; on cycle 10 pulse mthi_we wdata=0xAB -> busy=0 next cycle, no done, hi=0xAB, lo=0x22. Also: start held with mtlo_we=1 -> only lo written, busy stays 0.
- Start DIVU, assert rst on cycle 15 -> outputs zero immediately; after release busy=0, no done; a fresh MULTU 3*4 gives lo=12, hi=0.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
//   Iterative radix-2 multiply/divide unit holding the architectural HI/LO
//   registers. Multiplication is shift-add and division is restoring
//   shift-subtract, both on operand magnitudes. The sign correction is
//   applied in a final FIX cycle.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   start    request a mult/div op (sampled only when idle)
//   op       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b     rs / rt operands, latched on the start edge only
//   mthi_we  write wdata into HI (cancels an in-flight op)
//   mtlo_we  write wdata into LO (cancels an in-flight op)
//   wdata    MTHI/MTLO data
//   busy     op in flight (CALC or FIX)
//   done     one-cycle pulse after HI/LO take a result
//   hi, lo   HI / LO registers
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi_we,
    input  logic             mtlo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               neg_lo;     // negate product (mult) or quotient (div)
    logic               neg_hi;     // negate remainder (signed div, negative dividend)
    logic               div0;
    logic [WIDTH-1:0]   acc;        // product upper half / partial remainder
    logic [WIDTH-1:0]   low;        // multiplier->product lower half / dividend->quotient
    logic [WIDTH-1:0]   opnd;       // multiplicand magnitude / divisor magnitude

    logic               mt;
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [WIDTH-1:0]   acc_step, low_step;

    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign mt     = mthi_we | mtlo_we;
    assign busy   = (state != IDLE);

    // Signed ops (op[0]==0) work on magnitudes; 0x80000000 stays 0x80000000,
    // which is the correct unsigned magnitude.
    assign sign_a = ~op[0] & a[WIDTH-1];
    assign sign_b = ~op[0] & b[WIDTH-1];
    assign mag_a  = sign_a ? (~a + 1'b1) : a;
    assign mag_b  = sign_b ? (~b + 1'b1) : b;

    // One iteration step for each operation.
    always_comb begin
        mul_sum   = {1'b0, acc} + (low[0] ? {1'b0, opnd} : '0);
        div_shift = {acc, low[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd};
        if (is_div) begin
            // Restoring division: keep the trial difference only if non-negative.
            if (!div_trial[WIDTH]) begin
                acc_step = div_trial[WIDTH-1:0];
                low_step = {low[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = div_shift[WIDTH-1:0];
                low_step = {low[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_step = mul_sum[WIDTH:1];
            low_step = {mul_sum[0], low[WIDTH-1:1]};
        end
    end

    // Sign correction. A zero divisor drives every trial subtraction to
    // succeed, leaving remainder=|a| (sign-restored to a) and an all-ones
    // quotient that must not be negated.
    always_comb begin
        prod     = {acc, low};
        prod_fix = neg_lo ? (~prod + 1'b1) : prod;
        rem_fix  = neg_hi ? (~acc + 1'b1) : acc;
        if (div0)
            quo_fix = '1;
        else
            quo_fix = neg_lo ? (~low + 1'b1) : low;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start && !mt) state_next = CALC;
            CALC: begin
                if (mt)
                    state_next = IDLE;
                else if (cnt == '0)
                    state_next = FIX;
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            div0  <= 1'b0;
            acc   <= '0;
            low   <= '0;
            opnd  <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state == FIX) && !mt;

            if (state == IDLE && start && !mt) begin
                cnt    <= CNT_W'(WIDTH - 1);
                is_div <= op[1];
                neg_lo <= sign_a ^ sign_b;
                neg_hi <= op[1] & sign_a;
                div0   <= op[1] & (b == '0);
                acc    <= '0;
                low    <= op[1] ? mag_a : mag_b;
                opnd   <= op[1] ? mag_b : mag_a;
            end else if (state == CALC) begin
                cnt <= cnt - 1'b1;
                acc <= acc_step;
                low <= low_step;
            end

            // An mt write always wins and suppresses any pending result.
            if (mt) begin
                if (mthi_we) hi <= wdata;
                if (mtlo_we) lo <= wdata;
            end else if (state == FIX) begin
                if (is_div) begin
                    hi <= rem_fix;
                    lo <= quo_fix;
                end else begin
                    hi <= prod_fix[2*WIDTH-1:WIDTH];
                    lo <= prod_fix[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
module tb_hilo_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        mthi_we = 1'b0;
    logic        mtlo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    hilo_muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .mthi_we(mthi_we), .mtlo_we(mtlo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Stimulus helpers (no checks inside). All run from #1 after an edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        step();
        start = 1'b0;
    endtask

    // Counts busy cycles after the start edge and done pulses (incl. one cycle beyond).
    task automatic wait_done(output int cycles, output int dones, output int bad_overlap);
        cycles = 0; dones = 0; bad_overlap = 0;
        while (busy && cycles < 100) begin
            cycles++;
            step();
            if (done) begin
                dones++;
                if (busy) bad_overlap++;
            end
        end
        step();
        if (done) dones++;
    endtask

    task automatic mt_write(input logic whi, input logic wlo, input logic [31:0] d);
        mthi_we = whi; mtlo_we = wlo; wdata = d;
        step();
        mthi_we = 1'b0; mtlo_we = 1'b0;
    endtask

    task automatic test_reset();
        step();
        rst = 1'b0;
        checks++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi, lo);
        end
        $display("reset: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
    endtask

    task automatic test_multu();
        int cyc, dn, ov;
        issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(cyc, dn, ov);
        $display("MULTU ffffffff*ffffffff: cycles=%0d dones=%0d hi=%h lo=%h", cyc, dn, hi, lo);
        checks++; if (cyc !== 33) begin errors++; $display("FAIL multu_busy_cycles: got %0d, required 33", cyc); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL multu_done_count: got %0d, required 1", dn); end
        checks++; if (ov !== 0) begin errors++; $display("FAIL multu_done_busy_overlap: got %0d, required 0", ov); end
        checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi: got %h, required fffffffe", hi); end
        checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo: got %h, required 00000001", lo); end
    endtask

    task automatic test_mult_operand_hold();
        int cyc, dn, ov;
        issue(MULT, 32'hFFFFFFFD, 32'd7);
        a = 32'h12345678; b = 32'h9ABCDEF0;
        wait_done(cyc, dn, ov);
        $display("MULT -3*7 (operands changed): hi=%h lo=%h", hi, lo);
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h, required ffffffff", hi); end
        checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_lo: got %h, required ffffffeb", lo); end
    endtask

    task automatic test_div();
        int cyc, dn, ov;
        issue(DIV, 32'hFFFFFFF9, 32'd2);
        wait_done(cyc, dn, ov);
        $display("DIV -7/2: hi=%h lo=%h", hi, lo);
        checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo: got %h, required fffffffd", lo); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi: got %h, required ffffffff", hi); end

        issue(DIVU, 32'hFFFFFFF9, 32'd2);
        wait_done(cyc, dn, ov);
        $display("DIVU fffffff9/2: hi=%h lo=%h", hi, lo);
        checks++; if (lo !== 32'h7FFFFFFC) begin errors++; $display("FAIL divu_lo: got %h, required 7ffffffc", lo); end
        checks++; if (hi !== 32'h00000001) begin errors++; $display("FAIL divu_hi: got %h, required 00000001", hi); end

        issue(DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done(cyc, dn, ov);
        $display("DIV 80000000/ffffffff: hi=%h lo=%h", hi, lo);
        checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo: got %h, required 80000000", lo); end
        checks++; if (hi !== 32'h00000000) begin errors++; $display("FAIL div_ovf_hi: got %h, required 00000000", hi); end
    endtask

    task automatic test_div_by_zero();
        int cyc, dn, ov;
        issue(DIVU, 32'd100, 32'd0);
        wait_done(cyc, dn, ov);
        $display("DIVU 100/0: cycles=%0d hi=%h lo=%h", cyc, hi, lo);
        checks++; if (cyc !== 33) begin errors++; $display("FAIL div0_cycles: got %0d, required 33", cyc); end
        checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu0_lo: got %h, required ffffffff", lo); end
        checks++; if (hi !== 32'h00000064) begin errors++; $display("FAIL divu0_hi: got %h, required 00000064", hi); end

        issue(DIV, 32'hFFFFFFF9, 32'd0);
        wait_done(cyc, dn, ov);
        $display("DIV -7/0: hi=%h lo=%h", hi, lo);
        checks++; if (lo !== 32'hFFFFFFFF) begin errors++; $display("FAIL div0_lo: got %h, required ffffffff", lo); end
        checks++; if (hi !== 32'hFFFFFFF9) begin errors++; $display("FAIL div0_hi: got %h, required fffffff9", hi); end
    endtask

    task automatic test_mt_cancel();
        int dn;
        mt_write(1'b1, 1'b0, 32'h11);
        mt_write(1'b0, 1'b1, 32'h22);
        issue(MULTU, 32'd5, 32'd6);
        repeat (8) step();
        mt_write(1'b1, 1'b0, 32'hAB);
        $display("MTHI during MULTU: busy=%b hi=%h lo=%h", busy, hi, lo);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy: got %b, required 0", busy); end
        dn = 0;
        repeat (40) begin
            step();
            if (done) dn++;
        end
        checks++; if (dn !== 0) begin errors++; $display("FAIL cancel_no_done: got %0d pulses, required 0", dn); end
        checks++; if (hi !== 32'hAB) begin errors++; $display("FAIL cancel_hi: got %h, required 000000ab", hi); end
        checks++; if (lo !== 32'h22) begin errors++; $display("FAIL cancel_lo: got %h, required 00000022", lo); end

        start = 1'b1; op = MULTU; a = 32'd9; b = 32'd9;
        mt_write(1'b0, 1'b1, 32'h55);
        start = 1'b0;
        $display("MTLO with start: busy=%b hi=%h lo=%h", busy, hi, lo);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mt_start_busy: got %b, required 0", busy); end
        checks++; if (lo !== 32'h55) begin errors++; $display("FAIL mt_start_lo: got %h, required 00000055", lo); end
        checks++; if (hi !== 32'hAB) begin errors++; $display("FAIL mt_start_hi: got %h, required 000000ab", hi); end

        mt_write(1'b1, 1'b1, 32'h77);
        $display("MTHI+MTLO: hi=%h lo=%h", hi, lo);
        checks++; if ({hi, lo} !== {32'h77, 32'h77}) begin errors++; $display("FAIL mt_both: got %h/%h, required 00000077/00000077", hi, lo); end
    endtask

    task automatic test_reset_mid_op();
        int cyc, dn, ov, late;
        issue(DIVU, 32'd1000, 32'd7);
        repeat (14) step();
        #2 rst = 1'b1;
        #1;
        $display("async reset mid-op: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
        checks++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            errors++;
            $display("FAIL reset_immediate: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi, lo);
        end
        step();
        rst = 1'b0;
        late = 0;
        repeat (40) begin
            step();
            if (done || busy) late++;
        end
        checks++; if (late !== 0) begin errors++; $display("FAIL reset_no_resume: got %0d busy/done cycles, required 0", late); end

        issue(MULTU, 32'd3, 32'd4);
        wait_done(cyc, dn, ov);
        $display("MULTU 3*4 after reset: hi=%h lo=%h", hi, lo);
        checks++; if (lo !== 32'd12) begin errors++; $display("FAIL post_reset_lo: got %h, required 0000000c", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL post_reset_hi: got %h, required 00000000", hi); end
    endtask

    initial begin
        #1;
        test_reset();
        test_multu();
        test_mult_operand_hold();
        test_div();
        test_div_by_zero();
        test_mt_cancel();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
